fscale_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision scale-by-power-of-two unit: result = op × 2^k, where k is a signed per-operand input.
- Generalises the combinational halving unit (fixed k = −1) to any shift amount, with configurable pipeline depth and a valid/ready handshake.
- Adds overflow/underflow status.
- Sits in the FPU datapath beside the other single-precision units; feeds the result arbiter.

---
 rtl/fscale_pipe.sv | 95 +++++++++
 tb/tb_fscale_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fscale_pipe.sv
// Purpose: IEEE-754 single-precision scale by 2^k (k signed) with overflow/underflow flags.
// Latency: STAGES cycles from accept to out_valid; all arithmetic happens ahead of stage 1.
// Backpressure: one global enable (!out_valid || out_ready) freezes every stage; in_ready = enable.
module fscale_pipe #(
  parameter int KW     = 8,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   op,
  input  logic [KW-1:0] k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   result,
  output logic          ovf,
  output logic          unf
);

  // Wide enough that exp (0..255) plus any sign-extended k can never wrap.
  localparam int EW = ((KW > 9) ? KW : 9) + 2;

  logic                 w_sign;
  logic [7:0]           w_exp;
  logic [22:0]          w_fra;
  logic signed [EW-1:0] w_e;
  logic [31:0]          w_res;
  logic                 w_ovf;
  logic                 w_unf;
  logic                 w_en;

  logic                 r_vld [STAGES];
  logic [31:0]          r_res [STAGES];
  logic                 r_ovf [STAGES];
  logic                 r_unf [STAGES];

  assign w_sign = op[31];
  assign w_exp  = op[30:23];
  assign w_fra  = op[22:0];
  assign w_e    = $signed({{(EW-8){1'b0}}, w_exp}) + $signed({{(EW-KW){k[KW-1]}}, k});

  // Exponent adjust: specials pass through, denormals flush, out-of-range saturates or flushes.
  always_comb begin
    w_res = {w_sign, w_exp, w_fra};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (w_exp == 8'hFF) begin
      w_res = op;
    end else if (w_exp == 8'h00) begin
      w_res = {w_sign, 31'b0};
    end else if (w_e >= $signed(EW'(255))) begin
      w_res = {w_sign, 8'hFF, 23'b0};
      w_ovf = 1'b1;
    end else if (w_e <= $signed(EW'(0))) begin
      w_res = {w_sign, 31'b0};
      w_unf = 1'b1;
    end else begin
      w_res = {w_sign, w_e[7:0], w_fra};
    end
  end

  // A full output that is not being taken stalls the whole pipe, bubbles included.
  assign w_en     = !r_vld[STAGES-1] || out_ready;
  assign in_ready = w_en;

  // Stage 1 captures the finished result; later stages are pure delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= 1'b0;
        r_res[i] <= 32'b0;
        r_ovf[i] <= 1'b0;
        r_unf[i] <= 1'b0;
      end
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      r_res[0] <= w_res;
      r_ovf[0] <= w_ovf;
      r_unf[0] <= w_unf;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_res[i] <= r_res[i-1];
        r_ovf[i] <= r_ovf[i-1];
        r_unf[i] <= r_unf[i-1];
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign result    = r_res[STAGES-1];
  assign ovf       = r_ovf[STAGES-1];
  assign unf       = r_unf[STAGES-1];

endmodule

// File: tb/tb_fscale_pipe.sv
// Bench for fscale_pipe: directed vectors on a STAGES=2 instance, random sweeps on STAGES=1 and 4.
// A scoreboard per instance predicts every result from the exponent rules using integer math.
module tb_fscale_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] op        [3];
  logic [7:0]  k         [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] result    [3];
  logic        ovf       [3];
  logic        unf       [3];

  int checks = 0;
  int passes = 0;

  logic [33:0] q0 [$];
  logic [33:0] q1 [$];
  logic [33:0] q2 [$];
  logic        hold_v [3];
  logic [33:0] held   [3];
  logic [33:0] cmp_got;
  logic [33:0] cmp_exp;
  logic        sweeping;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fscale_pipe #(.KW(8), .STAGES((g == 0) ? 2 : ((g == 1) ? 1 : 4))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .op        (op[g]),
      .k         (k[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result[g]),
      .ovf       (ovf[g]),
      .unf       (unf[g])
    );
  end

  // Reference: {ovf, unf, result} straight from the arithmetic rules.
  function automatic logic [33:0] ref_fn(input logic [31:0] a, input logic [7:0] kk);
    int ex;
    int kv;
    int e;
    ex = int'(a[30:23]);
    kv = int'($signed(kk));
    e  = ex + kv;
    if (ex == 255) return {2'b00, a};
    if (ex == 0)   return {2'b00, a[31], 31'b0};
    if (e >= 255)  return {2'b10, a[31], 8'hFF, 23'b0};
    if (e <= 0)    return {2'b01, a[31], 31'b0};
    return {2'b00, a[31], e[7:0], a[22:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h required %h", nm, got, want);
  endtask

  function automatic int qsize(input int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int g, input logic [33:0] v);
    case (g)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int g, output logic [33:0] v);
    case (g)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  // Single compare process: handshakes are sampled mid-cycle, where inputs are stable.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        q0.delete();
        q1.delete();
        q2.delete();
        hold_v[g] = 1'b0;
      end else begin
        cmp_got = {ovf[g], unf[g], result[g]};
        if (hold_v[g]) begin
          chk($sformatf("stall_hold%0d", g), 64'({out_valid[g], cmp_got}), 64'({1'b1, held[g]}));
          hold_v[g] = 1'b0;
        end
        if (out_valid[g] === 1'b1) begin
          if (out_ready[g]) begin
            if (qsize(g) == 0) begin
              chk($sformatf("stale_out%0d", g), 64'(out_valid[g]), 64'(0));
            end else begin
              qpop(g, cmp_exp);
              chk($sformatf("model%0d", g), 64'(cmp_got), 64'(cmp_exp));
            end
          end else begin
            hold_v[g] = 1'b1;
            held[g]   = cmp_got;
          end
        end
        if (in_valid[g] && in_ready[g]) qpush(g, ref_fn(op[g], k[g]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int g, input logic [31:0] o, input logic [7:0] kk);
    int   n;
    logic acc;
    in_valid[g] = 1'b1;
    op[g]       = o;
    k[g]        = kk;
    n           = 0;
    do begin
      @(negedge clk);
      acc = in_ready[g];
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) chk($sformatf("send_timeout%0d", g), 64'(acc), 64'(1));
    in_valid[g] = 1'b0;
  endtask

  // One op through the empty STAGES=2 pipe: latency and literal result.
  task automatic run_one(input string nm, input logic [31:0] o, input logic [7:0] kk,
                         input logic [31:0] r, input logic fo, input logic fu);
    int   n;
    logic acc;
    in_valid[0] = 1'b1;
    op[0]       = o;
    k[0]        = kk;
    @(negedge clk);
    acc = in_ready[0];
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    chk({nm, "_accept"}, 64'(acc), 64'(1));
    n = 1;
    while (!out_valid[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(2));
    chk({nm, "_result"}, 64'({ovf[0], unf[0], result[0]}), 64'({fo, fu, r}));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] o;
    logic [7:0]  kk;
    logic [31:0] r;
    logic        fo;
    logic        fu;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] bp_res [3];
  int          got_n;
  int          wait_n;
  logic        saw_stale;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"half",     32'h3F800000, 8'hFF, 32'h3F000000, 1'b0, 1'b0};
    vecs[1]  = '{"zero",     32'h00000000, 8'hFF, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{"min_unf",  32'h00800000, 8'hFF, 32'h00000000, 1'b0, 1'b1};
    vecs[3]  = '{"nmin_unf", 32'h80800000, 8'hFF, 32'h80000000, 1'b0, 1'b1};
    vecs[4]  = '{"max_ovf",  32'h7F7FFFFF, 8'h01, 32'h7F800000, 1'b1, 1'b0};
    vecs[5]  = '{"k127",     32'h3F800000, 8'h7F, 32'h7F000000, 1'b0, 1'b0};
    vecs[6]  = '{"k_m128",   32'h3F800000, 8'h80, 32'h00000000, 1'b0, 1'b1};
    vecs[7]  = '{"nan",      32'h7FC00001, 8'h05, 32'h7FC00001, 1'b0, 1'b0};
    vecs[8]  = '{"ninf",     32'hFF800000, 8'hFD, 32'hFF800000, 1'b0, 1'b0};
    vecs[9]  = '{"denorm",   32'h00000001, 8'h14, 32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{"k0",       32'h3F800000, 8'h00, 32'h3F800000, 1'b0, 1'b0};
    vecs[11] = '{"neg",      32'hC0800000, 8'hFE, 32'hBF800000, 1'b0, 1'b0};

    sweeping = 1'b0;
    rst      = 1'b1;
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      op[g]        = 32'h0;
      k[g]         = 8'h0;
      out_ready[g] = 1'b1;
      hold_v[g]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_state", 64'({out_valid[0], ovf[0], unf[0], result[0]}), 64'(0));
    chk("pin_model_half", 64'(ref_fn(32'h3F800000, 8'hFF)), 64'({2'b00, 32'h3F000000}));
    chk("pin_model_ovf", 64'(ref_fn(32'h7F7FFFFF, 8'h01)), 64'({2'b10, 32'h7F800000}));

    foreach (vecs[i]) run_one(vecs[i].nm, vecs[i].o, vecs[i].kk, vecs[i].r, vecs[i].fo, vecs[i].fu);

    // Back-pressure: stall the first output for three cycles.
    fork
      begin
        send(0, 32'h40000000, 8'h01);
        send(0, 32'h40400000, 8'h02);
        send(0, 32'hC0800000, 8'hFE);
      end
      begin
        wait_n = 0;
        while (!out_valid[0] && wait_n < 20) begin
          @(posedge clk);
          #1;
          wait_n++;
        end
        out_ready[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          #1;
          chk("bp_hold_result", 64'({out_valid[0], result[0]}), 64'({1'b1, 32'h40800000}));
          chk("bp_in_ready", 64'(in_ready[0]), 64'(0));
          @(posedge clk);
          #1;
        end
        out_ready[0] = 1'b1;
        got_n  = 0;
        wait_n = 0;
        while (got_n < 3 && wait_n < 30) begin
          #1;
          if (out_valid[0]) begin
            bp_res[got_n] = result[0];
            got_n++;
          end
          @(posedge clk);
          #1;
          wait_n++;
        end
        chk("bp_count", 64'(got_n), 64'(3));
        chk("bp_r0", 64'(bp_res[0]), 64'(32'h40800000));
        chk("bp_r1", 64'(bp_res[1]), 64'(32'h41400000));
        chk("bp_r2", 64'(bp_res[2]), 64'(32'hBF800000));
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset with the pipe full.
    out_ready[0] = 1'b0;
    send(0, 32'h3F800000, 8'h01);
    send(0, 32'h40000000, 8'h01);
    chk("rst_prefill_valid", 64'(out_valid[0]), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_flush_valid", 64'(out_valid[0]), 64'(0));
    out_ready[0] = 1'b1;
    saw_stale    = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) saw_stale = 1'b1;
    end
    chk("rst_no_stale", 64'(saw_stale), 64'(0));
    run_one("post_rst", 32'h3F800000, 8'h00, 32'h3F800000, 1'b0, 1'b0);

    // Random sweep on STAGES=1 and STAGES=4 with random consumer readiness.
    sweeping = 1'b1;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 10000; i++) begin
              send(1, $urandom, 8'($urandom));
              if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
              end
            end
          end
          begin
            for (int i = 0; i < 10000; i++) begin
              send(2, $urandom, 8'($urandom));
              if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
              end
            end
          end
        join
        sweeping = 1'b0;
      end
      begin
        while (sweeping) begin
          @(posedge clk);
          #1;
          out_ready[1] = ($urandom_range(0, 3) != 0);
          out_ready[2] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready[1] = 1'b1;
    out_ready[2] = 1'b1;
    wait_n = 0;
    while ((qsize(1) != 0 || qsize(2) != 0) && wait_n < 50) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    chk("sweep_drain1", 64'(qsize(1)), 64'(0));
    chk("sweep_drain4", 64'(qsize(2)), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
